// File: rtl/sweep_sync_capture.sv
// sweep_sync_capture: arms on request, syncs to the chirp sweep-start pulse, waits a
// programmable delay, captures a decimated block of ADC samples into RAM and drains
// the block over a valid/ready stream.
// Ports:
//   sys_clk, reset_n        clock (rising edge) and asynchronous active-low reset
//   arm_i, abort_i          start a capture when idle / return to idle from any state
//   sweep_start_i           one-cycle sweep restart pulse, honoured only while waiting for sync
//   adc_data_i, adc_or_i    synchronized ADC sample and its overrange flag
//   delay_cycles_i, decim_i post-sync delay and decimation (one write every decim+1 cycles)
//   out_data_o, out_valid_o, out_ready_i, out_last_o  drained sample stream
//   busy_o, done_o          not idle / one-cycle pulse after the last sample is accepted
//   ovr_flag_o              sticky overrange seen on any captured sample of the block
//   state_o                 FSM state for the probe
module sweep_sync_capture #(
    parameter int DATA_W     = 14,
    parameter int DEPTH_LOG2 = 10,
    parameter int DELAY_W    = 16,
    parameter int DEC_W      = 8,
    parameter bit OUT_SIGNED = 1'b1
) (
    input  logic               sys_clk,
    input  logic               reset_n,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               sweep_start_i,
    input  logic [DATA_W-1:0]  adc_data_i,
    input  logic               adc_or_i,
    input  logic [DELAY_W-1:0] delay_cycles_i,
    input  logic [DEC_W-1:0]   decim_i,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               out_last_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovr_flag_o,
    output logic [2:0]         state_o
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SYNC = 3'd1,
        DELAY     = 3'd2,
        CAPTURE   = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    // XOR mask turning offset binary into two's complement
    localparam logic [DATA_W-1:0] MSB_FLIP = OUT_SIGNED ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

    state_t              state_q;
    logic [DELAY_W-1:0]  dly_cnt_q;
    logic [DEC_W-1:0]    dec_lat_q;
    logic [DEC_W-1:0]    dec_cnt_q;
    logic [DEPTH_LOG2-1:0] wr_addr_q;
    // Index of the next sample to load into the output register; MSB set = all loaded
    logic [DEPTH_LOG2:0] rd_addr_q;
    logic [DEPTH_LOG2:0] rd_addr_d;
    logic [DATA_W-1:0]   mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0]   rdat_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                done_q;
    logic                ovr_q;
    logic                wr_en;
    logic                load;

    assign wr_en = state_q == CAPTURE && dec_cnt_q == '0;
    // Output register can take a new sample when empty or being emptied this cycle
    assign load = state_q == DRAIN && (!out_valid_q || out_ready_i) && !rd_addr_q[DEPTH_LOG2];
    // RAM is addressed with the next-cycle index so rdat_q always holds mem[rd_addr_q],
    // which keeps one sample per cycle flowing and re-reads the same word while stalled
    assign rd_addr_d = load ? rd_addr_q + (DEPTH_LOG2+1)'(1) : rd_addr_q;

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_addr_q] <= adc_data_i;
        rdat_q <= mem[rd_addr_d[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dly_cnt_q   <= '0;
            dec_lat_q   <= '0;
            dec_cnt_q   <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                rd_addr_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (arm_i) begin
                        state_q   <= WAIT_SYNC;
                        ovr_q     <= 1'b0;
                        wr_addr_q <= '0;
                    end
                    WAIT_SYNC: if (sweep_start_i) begin
                        dly_cnt_q <= delay_cycles_i;
                        dec_lat_q <= decim_i;
                        dec_cnt_q <= '0;
                        state_q   <= delay_cycles_i == '0 ? CAPTURE : DELAY;
                    end
                    DELAY: begin
                        dly_cnt_q <= dly_cnt_q - DELAY_W'(1);
                        if (dly_cnt_q == DELAY_W'(1)) state_q <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (wr_en) begin
                            wr_addr_q <= wr_addr_q + DEPTH_LOG2'(1);
                            dec_cnt_q <= dec_lat_q;
                            ovr_q     <= ovr_q | adc_or_i;
                            if (&wr_addr_q) state_q <= DRAIN;
                        end else begin
                            dec_cnt_q <= dec_cnt_q - DEC_W'(1);
                        end
                    end
                    DRAIN: begin
                        rd_addr_q <= rd_addr_d;
                        if (load) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= rdat_q ^ MSB_FLIP;
                            out_last_q  <= &rd_addr_q[DEPTH_LOG2-1:0];
                        end else if (out_valid_q && out_ready_i) begin
                            // Only reachable when the last sample is accepted
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            rd_addr_q   <= '0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign done_o      = done_q;
    assign ovr_flag_o  = ovr_q;
    assign busy_o      = state_q != IDLE;
    assign state_o     = state_q;
endmodule

// File: tb/tb_sweep_sync_capture.sv
// tb_sweep_sync_capture: directed bench for sweep_sync_capture with a block-level
// expected-sample queue and a per-cycle stream checker.
module tb_sweep_sync_capture;
    localparam int N = 16;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm = 1'b0, abort = 1'b0, sweep = 1'b0, adc_or = 1'b0, out_ready = 1'b1;
    logic [13:0] adc_data = '0;
    logic [15:0] delay = '0;
    logic [7:0]  decim = '0;
    logic [13:0] out_data;
    logic        out_valid, out_last, busy, done, ovr_flag;
    logic [2:0]  state_o;

    always #5 sys_clk = ~sys_clk;

    sweep_sync_capture #(
        .DATA_W(14), .DEPTH_LOG2(4), .DELAY_W(16), .DEC_W(8), .OUT_SIGNED(1'b1)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .arm_i(arm), .abort_i(abort),
        .sweep_start_i(sweep), .adc_data_i(adc_data), .adc_or_i(adc_or),
        .delay_cycles_i(delay), .decim_i(decim), .out_data_o(out_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
        .busy_o(busy), .done_o(done), .ovr_flag_o(ovr_flag), .state_o(state_o)
    );

    int vecs = 0, errs = 0;
    int cyc = 0, or_cyc = -1, adc_mode = 0, hs = 0, t0 = 0;
    bit rand_rdy = 0, exp_ovr = 0, exp_done = 0, done_seen = 0, prev_stall = 0;
    logic [13:0] cval = '0, prev_data = '0, first_data = '0, second_data = '0;
    logic        prev_last = 1'b0;
    logic [13:0] exp_q[$];

    function automatic logic [13:0] adc_at(int c);
        return adc_mode == 1 ? cval : 14'(c);
    endfunction

    function automatic logic [13:0] fmt(logic [13:0] s);
        return s ^ 14'h2000;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    // Stimulus sources that change every cycle: cycle number, ADC ramp/constant, ready
    always @(posedge sys_clk) begin
        #1;
        cyc = cyc + 1;
        adc_data = adc_at(cyc);
        adc_or = (cyc == or_cyc);
        out_ready = rand_rdy ? ($urandom_range(0, 1) != 0) : 1'b1;
    end

    // Stream checker against the expected-sample queue
    always @(negedge sys_clk) begin
        if (!reset_n) begin
            prev_stall = 0;
            exp_done = 0;
        end else begin
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (exp_done && done) done_seen = 1;
            exp_done = 0;
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {18'd0, out_data}, {18'd0, prev_data});
                chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (exp_q.size() == 0) chk("no_valid", {31'd0, out_valid}, 32'd0);
            else if (out_valid && out_ready) begin
                logic [13:0] e;
                e = exp_q.pop_front();
                chk("data", {18'd0, out_data}, {18'd0, e});
                chk("last", {31'd0, out_last}, {31'd0, exp_q.size() == 0});
                chk("ovr", {31'd0, ovr_flag}, {31'd0, exp_ovr});
                if (hs == 0) first_data = out_data;
                if (hs == 1) second_data = out_data;
                hs++;
                if (exp_q.size() == 0) exp_done = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end
    end

    task automatic start_block(int d, int m, int or_k);
        delay = 16'(d);
        decim = 8'(m);
        hs = 0;
        arm = 1;
        tick();
        arm = 0;
        chk("arm_state", {29'd0, state_o}, 32'd1);
        chk("arm_busy", {31'd0, busy}, 32'd1);
        chk("arm_ovr_clear", {31'd0, ovr_flag}, 32'd0);
        tick(3);
        sweep = 1;
        t0 = cyc;
        or_cyc = or_k >= 0 ? t0 + d + 1 + or_k * (m + 1) : -1;
        exp_ovr = or_k >= 0;
        for (int k = 0; k < N; k++) exp_q.push_back(fmt(adc_at(t0 + d + 1 + k * (m + 1))));
        tick();
        sweep = 0;
        chk("sync_state", {29'd0, state_o}, d == 0 ? 32'd3 : 32'd2);
    endtask

    task automatic wait_done(int budget);
        done_seen = 0;
        for (int i = 0; i < budget && !done_seen; i++) tick();
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        chk("handshakes", hs, N);
        chk("idle_after", {29'd0, state_o}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_data", {18'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovr", {31'd0, ovr_flag}, 32'd0);
        reset_n = 1;
        tick(2);

        // sweep_start ignored while idle
        sweep = 1;
        tick();
        sweep = 0;
        chk("idle_ignore_sync", {29'd0, state_o}, 32'd0);

        // delay 0, decim 0: ramp values at T+1..T+16
        start_block(0, 0, -1);
        wait_done(200);
        chk("pin_a0", {18'd0, first_data}, {18'd0, 14'(t0 + 1) ^ 14'h2000});
        chk("pin_a1", {18'd0, second_data}, {18'd0, 14'(t0 + 2) ^ 14'h2000});

        // delay 5, decim 2: T+6, T+9, ...
        start_block(5, 2, -1);
        wait_done(300);
        chk("pin_b0", {18'd0, first_data}, {18'd0, 14'(t0 + 6) ^ 14'h2000});
        chk("pin_b1", {18'd0, second_data}, {18'd0, 14'(t0 + 9) ^ 14'h2000});

        // MSB inversion on constant inputs
        adc_mode = 1;
        cval = 14'h2000;
        start_block(3, 1, -1);
        wait_done(300);
        chk("signed_2000", {18'd0, first_data}, 32'h0000);
        cval = 14'h0000;
        start_block(0, 1, -1);
        wait_done(300);
        chk("signed_0000", {18'd0, first_data}, 32'h2000);
        adc_mode = 0;

        // random backpressure
        rand_rdy = 1;
        start_block(2, 1, -1);
        wait_done(500);
        rand_rdy = 0;

        // overrange on 3rd captured sample stays through drain and after
        start_block(1, 0, 2);
        wait_done(300);
        chk("ovr_held", {31'd0, ovr_flag}, 32'd1);

        // abort during capture (next arm also clears ovr)
        start_block(0, 3, -1);
        tick(10);
        chk("in_capture", {29'd0, state_o}, 32'd3);
        abort = 1;
        tick();
        abort = 0;
        exp_q.delete();
        chk("abort_state", {29'd0, state_o}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick(80);
        chk("abort_stays_idle", {29'd0, state_o}, 32'd0);

        // arm and abort together in idle
        arm = 1;
        abort = 1;
        tick();
        arm = 0;
        abort = 0;
        chk("arm_abort_idle", {29'd0, state_o}, 32'd0);

        // reset mid-drain
        start_block(0, 0, -1);
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        chk("drain_reached", {31'd0, out_valid}, 32'd1);
        tick(3);
        reset_n = 0;
        exp_q.delete();
        #1;
        chk("rstdrain_state", {29'd0, state_o}, 32'd0);
        chk("rstdrain_valid", {31'd0, out_valid}, 32'd0);
        chk("rstdrain_done", {31'd0, done}, 32'd0);
        tick();
        reset_n = 1;
        tick(30);

        // full block with arm/sweep_start during drain ignored
        start_block(2, 0, -1);
        for (int i = 0; i < 100 && state_o != 3'd4; i++) tick();
        chk("drain_state", {29'd0, state_o}, 32'd4);
        arm = 1;
        sweep = 1;
        tick();
        arm = 0;
        sweep = 0;
        chk("drain_ignores", {29'd0, state_o}, 32'd4);
        wait_done(300);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sweep_sync_capture.md
Name: sweep_sync_capture

Overview:
Receive-side partner of the chirp NCO transmit path. Arms on request and waits for the sweep-start pulse from the chirp sweep controller. It then waits a programmable delay, captures a decimated block of synchronized ADC samples into on-chip RAM, and drains the block over a valid/ready stream toward probe/readout logic. It sits after the ADC capture registers (sys_clk domain) and in parallel with the low-pass FIR.

Parameters:
DATA_W, 14, ADC sample width
DEPTH_LOG2, 10, log2 of capture block length (samples per block = 2^DEPTH_LOG2)
DELAY_W, 16, width of post-sync delay counter
DEC_W, 8, width of decimation control
OUT_SIGNED, 1, 1 = invert sample MSB on output (offset binary to two's complement); 0 = pass through

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
arm  in  1  one-cycle request to start a capture
abort  in  1  synchronous abort; highest priority after reset
sweep_start  in  1  one-cycle pulse when the chirp phase increment restarts
adc_data  in  DATA_W  ADC sample, already synchronized to sys_clk
adc_or  in  1  ADC overrange flag aligned with adc_data
delay_cycles  in  DELAY_W  sys_clk cycles between sweep_start and first capture
decim  in  DEC_W  capture one sample every decim+1 cycles
out_data  out  DATA_W  drained sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_last  out  1  high with the final sample of the block
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final sample is accepted
ovr_flag  out  1  sticky: adc_or seen on any captured sample of current block
state_o  out  3  current FSM state encoding, for the probe

Behaviour:
- Reset: state IDLE. out_valid=0, out_last=0, out_data=0, busy=0, done=0, ovr_flag=0. All counters = 0. RAM contents are don't-care.
- State encodings: IDLE=0, WAIT_SYNC=1, DELAY=2, CAPTURE=3, DRAIN=4.
- IDLE: arm -> WAIT_SYNC. On arm, clear ovr_flag and write address. sweep_start is ignored in IDLE.
- WAIT_SYNC: sweep_start -> latch delay_cycles and decim.
  - Latched delay = 0: go to CAPTURE next cycle.
  - Otherwise: go to DELAY with counter = delay_cycles.
- DELAY: counter decrements each cycle. When counter = 1, go to CAPTURE.
  - First captured sample is adc_data exactly delay_cycles+1 cycles after the sweep_start cycle (1 cycle when delay = 0).
- CAPTURE:
  - The first CAPTURE cycle writes a sample. Thereafter, write every (latched decim)+1 cycles.
  - Write address increments per write, 0 up to 2^DEPTH_LOG2-1.
  - ovr_flag |= adc_or on write cycles only.
  - After the write at the last address, go to DRAIN.
- DRAIN:
  - RAM has 1-cycle read latency. A prefetch/skid register ensures out_valid asserts no later than 2 cycles after DRAIN entry.
  - out_data and out_last hold stable while out_valid & !out_ready.
  - Back-to-back transfers sustain one sample per cycle when out_ready stays high.
  - out_data = {~s[MSB], s[MSB-1:0]} when OUT_SIGNED=1.
  - out_last is high only with read address 2^DEPTH_LOG2-1.
  - On acceptance of the last sample: go to IDLE, pulse done for 1 cycle, out_valid=0.
- arm while busy: ignored.
- sweep_start outside WAIT_SYNC: ignored; no retrigger.
- abort in any state: go to IDLE next cycle, out_valid=0, out_last=0, no done pulse. ovr_flag is held.
- arm and abort in the same IDLE cycle: abort wins; stay IDLE.
- Reset mid-operation: immediate return to reset values. A partially drained block is discarded.
- Decimation counter and address counters wrap only via terminal count. No sample is written after the last address.
- Latched decim/delay are unaffected by input changes during DELAY/CAPTURE.

Test Plan:
- DEPTH_LOG2=4, delay=0, decim=0, adc_data=ramp 0..: arm, pulse sweep_start at cycle T -> 16 samples equal to ramp values at T+1..T+16; out_last on the 16th; done one cycle after the last handshake.
- delay=5, decim=2 -> captured values taken at T+6, T+9, T+12, ...; 16 samples.
- OUT_SIGNED=1, adc_data=14'h2000 constant -> out_data=14'h0000. adc_data=14'h0000 -> 14'h2000.
- Drain with out_ready toggling 1,0,0,1 pseudo-randomly -> no sample lost or duplicated; out_data stable while stalled; exactly 16 handshakes.
- adc_or high only on the 3rd captured sample -> ovr_flag=1 through drain. Next arm clears it to 0.
- abort during CAPTURE and reset_n low during DRAIN -> state_o=0, out_valid=0, no done. A second arm with sweep_start yields a full correct block. arm and sweep_start during DRAIN are ignored.
